// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - segment-bus scan receiver that rebuilds four-digit BCD frames
// Optional binary value output enabled by defining SEG_SCAN_BIN_EN.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [1:0]  sel_in,
    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
`ifdef SEG_SCAN_BIN_EN
    output logic [13:0] bin_value,
`endif
    output logic        frame_err
);

    localparam logic [7:0] STABLE_THR = 8'(STABLE_CYCLES);

    logic [7:0]       s_seg;
    logic [1:0]       s_sel;
    logic [7:0]       p_seg;
    logic [1:0]       p_sel;
    logic [7:0]       stab_cnt;
    logic [7:0]       cnt_next;
    logic             sample_diff;
    logic             capture;

    logic [3:0]       seen;
    logic [3:0]       seen_next;
    logic [3:0][3:0]  slot_digit;
    logic [3:0]       slot_blank;
    logic [3:0]       slot_inv;

    logic [3:0][3:0]  m_digit;
    logic [3:0]       m_blank;
    logic [3:0]       m_inv;
    logic [3:0]       dec_digit;
    logic             dec_blank;
    logic             dec_inv;
    logic             frame_done;
    logic             err_next;
    logic             above_blank;

    // Bit 7 (decimal point) is ignored; blank slots decode to 0, invalid ones to F.
    function automatic logic [5:0] decode(input logic [6:0] pat);
        logic [5:0] r;
        r = 6'b000000;
        case (pat)
            7'h7E:   r[3:0] = 4'd0;
            7'h48:   r[3:0] = 4'd1;
            7'h3D:   r[3:0] = 4'd2;
            7'h6D:   r[3:0] = 4'd3;
            7'h4B:   r[3:0] = 4'd4;
            7'h67:   r[3:0] = 4'd5;
            7'h77:   r[3:0] = 4'd6;
            7'h4C:   r[3:0] = 4'd7;
            7'h7F:   r[3:0] = 4'd8;
            7'h6F:   r[3:0] = 4'd9;
            7'h00:   r[5]   = 1'b1;
            default: r      = {1'b0, 1'b1, 4'hF};
        endcase
        return r;
    endfunction

    always_comb begin
        sample_diff = ({s_sel, s_seg} != {p_sel, p_seg});
        if (sample_diff) begin
            cnt_next = 8'd1;
        end else if (stab_cnt == 8'hFF) begin
            cnt_next = 8'hFF;
        end else begin
            cnt_next = stab_cnt + 8'd1;
        end
        // A counter already saturated at the threshold must not fire again.
        capture = (cnt_next == STABLE_THR) && (sample_diff || (stab_cnt != STABLE_THR));
        {dec_blank, dec_inv, dec_digit} = decode(s_seg[6:0]);
    end

    // Slot view including the capture happening this cycle.
    always_comb begin
        m_digit   = slot_digit;
        m_blank   = slot_blank;
        m_inv     = slot_inv;
        seen_next = seen;
        if (capture) begin
            m_digit[s_sel]   = dec_digit;
            m_blank[s_sel]   = dec_blank;
            m_inv[s_sel]     = dec_inv;
            seen_next[s_sel] = 1'b1;
        end
        frame_done = capture && (seen_next == 4'hF);
    end

    always_comb begin
        err_next = (|m_inv) | m_blank[0];
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (m_blank[i] && !m_blank[j]) begin
                    err_next = 1'b1;
                end
            end
        end
        // A displayed leading zero means the driver failed to blank it.
        for (int n = 1; n < 4; n++) begin
            above_blank = 1'b1;
            for (int k = 3; k > n; k--) begin
                above_blank = above_blank & m_blank[k];
            end
            if (!m_blank[n] && !m_inv[n] && (m_digit[n] == 4'd0) && above_blank) begin
                err_next = 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_BIN_EN
    logic [13:0] bin_next;

    always_comb begin
        if (|m_inv) begin
            bin_next = 14'h3FFF;
        end else begin
            bin_next = 14'(m_digit[3]) * 14'd1000 + 14'(m_digit[2]) * 14'd100
                     + 14'(m_digit[1]) * 14'd10 + 14'(m_digit[0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_value <= 14'd0;
        end else if (frame_done) begin
            bin_value <= bin_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg    <= 8'd0;
            s_sel    <= 2'd0;
            p_seg    <= 8'd0;
            p_sel    <= 2'd0;
            stab_cnt <= 8'd0;
        end else begin
            s_seg    <= seg_in;
            s_sel    <= sel_in;
            p_seg    <= s_seg;
            p_sel    <= s_sel;
            stab_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen       <= 4'd0;
            slot_digit <= '0;
            slot_blank <= 4'd0;
            slot_inv   <= 4'd0;
        end else begin
            seen       <= frame_done ? 4'd0 : seen_next;
            slot_digit <= m_digit;
            slot_blank <= m_blank;
            slot_inv   <= m_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit0      <= 4'd0;
            digit1      <= 4'd0;
            digit2      <= 4'd0;
            digit3      <= 4'd0;
            blank_mask  <= 4'hE;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                digit0     <= m_digit[0];
                digit1     <= m_digit[1];
                digit2     <= m_digit[2];
                digit3     <= m_digit[3];
                blank_mask <= m_blank;
                frame_err  <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic [1:0]  sel_in;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic [3:0]  blank_mask;
    logic        frame_valid;
    logic        frame_err;
`ifdef SEG_SCAN_BIN_EN
    logic [13:0] bin_value;
`endif

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic        err;
        logic [13:0] bin;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     passes = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .blank_mask  (blank_mask),
        .frame_valid (frame_valid),
`ifdef SEG_SCAN_BIN_EN
        .bin_value   (bin_value),
`endif
        .frame_err   (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, {16'd0, digit3, digit2, digit1, digit0}, 32'h0);
        check({tag, "_blank"}, {28'd0, blank_mask}, 32'hE);
        check({tag, "_err"}, {31'd0, frame_err}, 32'h0);
        check({tag, "_valid"}, {31'd0, frame_valid}, 32'h0);
`ifdef SEG_SCAN_BIN_EN
        check({tag, "_bin"}, {18'd0, bin_value}, 32'h0);
`endif
    endtask

    task automatic hold(input logic [1:0] sel, input logic [7:0] seg, input int n);
        sel_in = sel;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input logic [15:0] d, input logic [3:0] b,
                                input logic e, input logic [13:0] bin);
        frame_t f;
        f.digits = d;
        f.blank  = b;
        f.err    = e;
        f.bin    = bin;
        exp_q.push_back(f);
    endtask

    task automatic scan4(input logic [7:0] p3, input logic [7:0] p2,
                         input logic [7:0] p1, input logic [7:0] p0);
        hold(2'd3, p3, 10);
        hold(2'd2, p2, 10);
        hold(2'd1, p1, 10);
        hold(2'd0, p0, 10);
    endtask

    // Monitor: every frame_valid pulse consumes one expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_frame_valid: got pulse expected none, digits %h%h%h%h",
                         digit3, digit2, digit1, digit0);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_digits", {16'd0, digit3, digit2, digit1, digit0}, {16'd0, f.digits});
                check("frame_blank", {28'd0, blank_mask}, {28'd0, f.blank});
                check("frame_err", {31'd0, frame_err}, {31'd0, f.err});
`ifdef SEG_SCAN_BIN_EN
                check("frame_bin", {18'd0, bin_value}, {18'd0, f.bin});
`endif
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        sel_in = 2'd3;
        seg_in = 8'h48;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        expect_frame(16'h1234, 4'h0, 1'b0, 14'd1234);
        scan4(8'h48, 8'h3D, 8'h6D, 8'h4B);

        expect_frame(16'h0010, 4'hC, 1'b0, 14'd10);
        scan4(8'h00, 8'h00, 8'h48, 8'h7E);

        // Short stretches on slot 1 (3 and 2 samples) must never be captured.
        expect_frame(16'h0013, 4'hC, 1'b0, 14'd13);
        hold(2'd3, 8'h00, 10);
        hold(2'd2, 8'h00, 10);
        hold(2'd1, 8'h48, 3);
        hold(2'd1, 8'h7F, 2);
        hold(2'd1, 8'h48, 10);
        hold(2'd0, 8'h6D, 10);

        expect_frame(16'h1F34, 4'h0, 1'b1, 14'h3FFF);
        scan4(8'h48, 8'h55, 8'h6D, 8'h4B);

        expect_frame(16'h1034, 4'h4, 1'b1, 14'd1034);
        scan4(8'h48, 8'h00, 8'h6D, 8'h4B);

        expect_frame(16'h0123, 4'h0, 1'b1, 14'd123);
        scan4(8'h7E, 8'h48, 8'h3D, 8'h6D);

        expect_frame(16'h0000, 4'hF, 1'b1, 14'd0);
        scan4(8'h00, 8'h00, 8'h00, 8'h00);

        // Decimal-point bit set on every slot.
        expect_frame(16'h0123, 4'h8, 1'b0, 14'd123);
        scan4(8'h80, 8'hC8, 8'hBD, 8'hED);

        // Slot 3 recaptured before the frame completes.
        expect_frame(16'h3245, 4'h0, 1'b0, 14'd3245);
        hold(2'd3, 8'h48, 10);
        hold(2'd2, 8'h3D, 10);
        hold(2'd3, 8'h6D, 10);
        hold(2'd1, 8'h4B, 10);
        hold(2'd0, 8'h67, 10);

        // Partial frame lost to reset.
        hold(2'd3, 8'h48, 10);
        hold(2'd2, 8'h3D, 10);
        hold(2'd1, 8'h6D, 10);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        sel_in = 2'd3;
        seg_in = 8'h4B;
        @(negedge clk);
        rst_n = 1'b1;
        hold(2'd3, 8'h4B, 10);
        hold(2'd2, 8'h6D, 10);
        hold(2'd1, 8'h3D, 10);
        check_reset_outputs("postreset");
        check("no_frame_after_reset", exp_q.size(), 32'd0);
        expect_frame(16'h4321, 4'h0, 1'b0, 14'd4321);
        hold(2'd0, 8'h48, 10);

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
